// File: rtl/fibo_pkg.sv
// Shared types for the Fibonacci request/response sequencer.
package fibo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fibo_step.sv
// One Fibonacci step: (a, b) -> (b, a+b) with sticky overflow flags; purely combinational.
module fibo_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ovf,
  input  logic             b_ovf,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             a_ovf_nxt,
  output logic             b_ovf_nxt
);

  logic [WIDTH:0] sum;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign a_nxt     = b;
  assign b_nxt     = sum[WIDTH-1:0];
  assign a_ovf_nxt = b_ovf;
  // Once either term has wrapped, every later term is also too large.
  assign b_ovf_nxt = sum[WIDTH] | a_ovf | b_ovf;

endmodule

// File: rtl/fibo_seq_ctrl.sv
// Accepts index N, steps fibo_step N times, returns F(N) mod 2^WIDTH plus overflow.
// Response at accept+N+2 cycles; result held in DONE until resp_ready, no new request until then.
module fibo_seq_ctrl
  import fibo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [NW-1:0]    req_n,
  output logic             req_ready,
  input  logic             abort,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_ovf,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, a_nxt, b_nxt;
  logic             a_ovf, b_ovf, a_ovf_nxt, b_ovf_nxt;
  logic [NW-1:0]    cnt;

  fibo_step #(.WIDTH(WIDTH)) u_step (
    .a         (a),
    .b         (b),
    .a_ovf     (a_ovf),
    .b_ovf     (b_ovf),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .a_ovf_nxt (a_ovf_nxt),
    .b_ovf_nxt (b_ovf_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_RUN;
      // abort takes priority over the terminal check
      ST_RUN: begin
        if (abort)            state_nxt = ST_IDLE;
        else if (cnt == '0)   state_nxt = ST_DONE;
      end
      ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    busy       = (state == ST_RUN);
    resp_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a         <= '0;
      b         <= WIDTH'(1);
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
      cnt       <= '0;
      resp_data <= '0;
      resp_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a     <= '0;
            b     <= WIDTH'(1);
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            cnt   <= req_n;
          end
        end
        ST_RUN: begin
          if (!abort) begin
            if (cnt == '0) begin
              resp_data <= a;
              resp_ovf  <= a_ovf;
            end else begin
              a     <= a_nxt;
              b     <= b_nxt;
              a_ovf <= a_ovf_nxt;
              b_ovf <= b_ovf_nxt;
              cnt   <= cnt - NW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Bench for fibo_seq_ctrl: fixed vector table, corner-case sequences, random indices vs. a reference model.
module tb_fibo_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int NW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [NW-1:0]    req_n;
  logic             req_ready;
  logic             abort;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_ovf;
  logic             busy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fibo_seq_ctrl #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_n      (req_n),
    .req_ready  (req_ready),
    .abort      (abort),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_ovf   (resp_ovf),
    .busy       (busy)
  );

  typedef struct {
    int          n;
    logic [31:0] d;
    bit          o;
    bit          chk_d;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Exact Fibonacci with a saturating copy to decide whether F(n) reaches 2^32.
  task automatic ref_fib(input int n, output logic [31:0] d, output bit o);
    longint unsigned fa = 0, fb = 1, t;
    longint unsigned cap = 64'h2_0000_0000;
    logic [31:0] wa = 0, wb = 1, wt;
    for (int k = 0; k < n; k++) begin
      t  = fa + fb;
      fa = fb;
      fb = (t > cap) ? cap : t;
      wt = wa + wb;
      wa = wb;
      wb = wt;
    end
    d = wa;
    o = (fa >= 64'h1_0000_0000);
  endtask

  task automatic run_req(input int n, output logic [31:0] d, output logic o,
                         output int lat, output bit to);
    logic [NW-1:0] nn;
    nn = n[NW-1:0];
    check("req_ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_n     = nn;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    to  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (resp_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    d = resp_data;
    o = resp_ovf;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic req_and_check(input string nm, input int n, input logic [31:0] ed,
                               input bit eo, input bit chk_d);
    logic [31:0] d;
    logic        o;
    int          lat;
    bit          to;
    run_req(n, d, o, lat, to);
    check({nm, "_timeout"}, {63'd0, to}, 64'd0);
    check({nm, "_latency"}, lat, n + 2);
    if (chk_d) check({nm, "_data"}, d, ed);
    check({nm, "_ovf"}, {63'd0, o}, {63'd0, eo});
  endtask

  initial begin
    logic [31:0] md, hold_d;
    bit          mo;
    int          rn;

    tbl[0] = '{n: 10,  d: 32'd55,         o: 1'b0, chk_d: 1'b1};
    tbl[1] = '{n: 0,   d: 32'd0,          o: 1'b0, chk_d: 1'b1};
    tbl[2] = '{n: 1,   d: 32'd1,          o: 1'b0, chk_d: 1'b1};
    tbl[3] = '{n: 2,   d: 32'd1,          o: 1'b0, chk_d: 1'b1};
    tbl[4] = '{n: 47,  d: 32'd2971215073, o: 1'b0, chk_d: 1'b1};
    tbl[5] = '{n: 48,  d: 32'd512559680,  o: 1'b1, chk_d: 1'b1};
    tbl[6] = '{n: 255, d: 32'd0,          o: 1'b1, chk_d: 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_n = '0; abort = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_req_ready",  {63'd0, req_ready},  64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_busy",       {63'd0, busy},       64'd0);
    check("rst_resp_data",  resp_data,           64'd0);
    check("rst_resp_ovf",   {63'd0, resp_ovf},   64'd0);

    foreach (tbl[i])
      req_and_check($sformatf("tbl_n%0d", tbl[i].n), tbl[i].n, tbl[i].d, tbl[i].o, tbl[i].chk_d);

    // Backpressure: hold DONE for 5 cycles with a competing request.
    req_valid = 1'b1; req_n = 8'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !resp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid", {63'd0, resp_valid}, 64'd1);
    hold_d = resp_data;
    check("bp_data", hold_d, 64'd8);
    req_valid = 1'b1; req_n = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data",  resp_data, 64'd8);
      check("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_req_ready",  {63'd0, req_ready},  64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_release_ready", {63'd0, req_ready}, 64'd1);
    check("bp_release_busy",  {63'd0, busy},      64'd0);
    req_and_check("bp_next", 9, 32'd34, 1'b0, 1'b1);

    // Abort on the third RUN cycle of N=20.
    req_valid = 1'b1; req_n = 8'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy",      {63'd0, busy},       64'd0);
    check("abort_req_ready", {63'd0, req_ready},  64'd1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
        if (resp_valid) seen = 1'b1;
        @(posedge clk); #1;
      end
      check("abort_no_resp", {63'd0, seen}, 64'd0);
    end
    req_and_check("abort_next", 5, 32'd5, 1'b0, 1'b1);

    // Synchronous reset in the middle of RUN for N=30.
    req_valid = 1'b1; req_n = 8'd30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req_ready",  {63'd0, req_ready},  64'd1);
    check("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("mid_rst_busy",       {63'd0, busy},       64'd0);
    check("mid_rst_resp_data",  resp_data,           64'd0);
    check("mid_rst_resp_ovf",   {63'd0, resp_ovf},   64'd0);
    reset = 1'b0;
    req_and_check("mid_rst_next", 7, 32'd13, 1'b0, 1'b1);

    // Random indices against the reference model.
    for (int i = 0; i < 16; i++) begin
      rn = (i % 5 == 4) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 80));
      ref_fib(rn, md, mo);
      req_and_check($sformatf("rnd_n%0d", rn), rn, md, mo, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
